tag_array_assoc: RTL and testbench

Parametrised set-associative tag store for the data cache: holds tag, valid and dirty state per way, and compares a lookup tag against every way of the addressed set. Returns a registered hit/miss result with the hit way and a replacement victim. Provides a hardware invalidate sweep after reset and on request. Sits between the data-cache controller FSM and the data RAM banks, and replaces the single-way tag RAM.

---
 rtl/tag_array_assoc.sv | 227 ++++++++++++++++++++++
 tb/tb_tag_array_assoc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tag_array_assoc.sv
// Set-associative tag store: registered lookup with hit way and replacement victim, plus invalidate sweep.
// Build option TAG_ARRAY_PLRU_EN selects tree pseudo-LRU; otherwise a global round-robin victim counter.
module tag_array_assoc #(
  parameter int TAG_W   = 12,
  parameter int INDEX_W = 7,
  parameter int WAYS    = 2,
  parameter int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               LookupEn,
  input  logic [INDEX_W-1:0] LookupIndex,
  input  logic [TAG_W-1:0]   LookupTag,
  output logic               Hit,
  output logic               Miss,
  output logic [WAY_W-1:0]   HitWay,
  output logic [WAY_W-1:0]   VictimWay,
  output logic               VictimDirty,
  output logic [TAG_W-1:0]   VictimTag,
  input  logic               FillEn,
  input  logic [INDEX_W-1:0] FillIndex,
  input  logic [WAY_W-1:0]   FillWay,
  input  logic [TAG_W-1:0]   FillTag,
  input  logic               FillDirty,
  input  logic               MarkDirty,
  input  logic               InvalidateAll,
  output logic               Busy
);
  localparam int SETS = 2 ** INDEX_W;

  typedef enum logic [1:0] {INIT, IDLE, SWEEP} state_t;
  state_t             state_reg, state_next;
  logic [INDEX_W-1:0] sweep_cnt_reg, sweep_cnt_next;
  logic               idle;

  logic               lookup_ok, fill_ok, mark_ok;
  logic               res_valid_reg;
  logic [INDEX_W-1:0] res_index_reg;
  logic [TAG_W-1:0]   res_tag_reg;
  logic [WAYS-1:0]    valid_rd_reg, dirty_rd_reg;
  logic [WAYS-1:0]    valid_mem [SETS];
  logic [WAYS-1:0]    dirty_mem [SETS];
  logic [TAG_W-1:0]   tag_rd [WAYS];
  logic [WAYS-1:0]    match;
  logic               hit_any, set_full;
  logic [WAY_W-1:0]   hit_way, free_way, victim_way;
  logic [WAYS-1:0]    fwd_dirty;

`ifdef TAG_ARRAY_PLRU_EN
  localparam int LRU_W  = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int LEVELS = (WAYS > 1) ? WAY_W : 0;
  logic [LRU_W-1:0] lru_mem [SETS];
  logic [LRU_W-1:0] lru_rd_reg, fwd_lru;

  // Tree nodes are heap-ordered; a node bit names the subtree holding the next victim.
  function automatic logic [LRU_W-1:0] plru_touch(input logic [LRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0] way);
    logic [LRU_W-1:0] t;
    int node;
    t    = bits;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      t[node] = ~way[LEVELS-1-l];
      node    = 2 * node + 1 + int'(way[LEVELS-1-l]);
    end
    return t;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [LRU_W-1:0] bits);
    logic [WAY_W-1:0] v;
    int node;
    v    = '0;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      v[LEVELS-1-l] = bits[node];
      node          = 2 * node + 1 + int'(bits[node]);
    end
    return v;
  endfunction
`else
  logic [WAY_W-1:0] rr_reg;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg     <= INIT;
      sweep_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_cnt_reg <= sweep_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sweep_cnt_next = sweep_cnt_reg;
    idle           = 1'b0;
    case (state_reg)
      IDLE: begin
        idle = 1'b1;
        if (InvalidateAll) begin
          state_next     = SWEEP;
          sweep_cnt_next = '0;
        end
      end
      INIT, SWEEP: begin
        sweep_cnt_next = sweep_cnt_reg + 1'b1;
        if (&sweep_cnt_reg) state_next = IDLE;
      end
      default: begin
        state_next     = INIT;
        sweep_cnt_next = '0;
      end
    endcase
  end

  // Busy must read 0 while reset is held yet 1 from the instant it is released.
  assign Busy      = nReset & ~idle;
  assign lookup_ok = idle & LookupEn & ~InvalidateAll;
  assign fill_ok   = idle & FillEn & ~InvalidateAll;
  assign mark_ok   = idle & MarkDirty & hit_any;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [TAG_W-1:0] tag_mem [SETS];
    logic [TAG_W-1:0] rd_reg;
    always_ff @(posedge clk) begin
      if (fill_ok && FillWay == WAY_W'(gi)) tag_mem[FillIndex] <= FillTag;
      if (lookup_ok) rd_reg <= tag_mem[LookupIndex];
    end
    assign tag_rd[gi] = rd_reg;
    assign match[gi]  = valid_rd_reg[gi] && (rd_reg == res_tag_reg);
  end

  always_ff @(posedge clk) begin
    if (!idle) begin
      valid_mem[sweep_cnt_reg] <= '0;
      dirty_mem[sweep_cnt_reg] <= '0;
`ifdef TAG_ARRAY_PLRU_EN
      lru_mem[sweep_cnt_reg]   <= '0;
`endif
    end else begin
      if (mark_ok) dirty_mem[res_index_reg][hit_way] <= 1'b1;
`ifdef TAG_ARRAY_PLRU_EN
      if (hit_any) lru_mem[res_index_reg] <= plru_touch(lru_mem[res_index_reg], hit_way);
`endif
      if (fill_ok) begin
        valid_mem[FillIndex][FillWay] <= 1'b1;
        dirty_mem[FillIndex][FillWay] <= FillDirty;
`ifdef TAG_ARRAY_PLRU_EN
        lru_mem[FillIndex]            <= plru_touch(lru_mem[FillIndex], FillWay);
`endif
      end
    end
  end

  // Forward this cycle's hit/MarkDirty updates into a back-to-back lookup of the same set.
  always_comb begin
    fwd_dirty = dirty_mem[LookupIndex];
`ifdef TAG_ARRAY_PLRU_EN
    fwd_lru   = lru_mem[LookupIndex];
`endif
    if (LookupIndex == res_index_reg) begin
      if (mark_ok) fwd_dirty[hit_way] = 1'b1;
`ifdef TAG_ARRAY_PLRU_EN
      if (hit_any) fwd_lru = plru_touch(fwd_lru, hit_way);
`endif
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      res_valid_reg <= 1'b0;
      res_index_reg <= '0;
      res_tag_reg   <= '0;
      valid_rd_reg  <= '0;
      dirty_rd_reg  <= '0;
`ifdef TAG_ARRAY_PLRU_EN
      lru_rd_reg    <= '0;
`endif
    end else begin
      res_valid_reg <= lookup_ok;
      if (lookup_ok) begin
        res_index_reg <= LookupIndex;
        res_tag_reg   <= LookupTag;
        valid_rd_reg  <= valid_mem[LookupIndex];
        dirty_rd_reg  <= fwd_dirty;
`ifdef TAG_ARRAY_PLRU_EN
        lru_rd_reg    <= fwd_lru;
`endif
      end
    end
  end

  always_comb begin
    hit_way  = '0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_W'(w);
      if (!valid_rd_reg[w]) free_way = WAY_W'(w);
    end
    set_full = &valid_rd_reg;
    hit_any  = res_valid_reg & (|match);
`ifdef TAG_ARRAY_PLRU_EN
    victim_way = set_full ? plru_victim(lru_rd_reg) : free_way;
`else
    victim_way = set_full ? rr_reg : free_way;
`endif
  end

`ifndef TAG_ARRAY_PLRU_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rr_reg <= '0;
    end else if (Miss && set_full) begin
      rr_reg <= (rr_reg == WAY_W'(WAYS - 1)) ? '0 : rr_reg + 1'b1;
    end
  end
`endif

  assign Hit         = hit_any;
  assign Miss        = res_valid_reg & ~(|match);
  assign HitWay      = hit_any ? hit_way : '0;
  assign VictimWay   = res_valid_reg ? victim_way : '0;
  assign VictimDirty = res_valid_reg & valid_rd_reg[victim_way] & dirty_rd_reg[victim_way];
  assign VictimTag   = res_valid_reg ? tag_rd[victim_way] : '0;

endmodule

// File: tb/tb_tag_array_assoc.sv
// Scoreboard bench for tag_array_assoc: lookups queue their expected result, a negedge monitor compares.
// Expectations follow the default (round-robin) build unless TAG_ARRAY_PLRU_EN is defined.
module tb_tag_array_assoc;
  localparam int TAG_W   = 12;
  localparam int INDEX_W = 7;
  localparam int WAYS    = 2;
  localparam int WAY_W   = 1;
  localparam int SETS    = 128;

  logic               clk = 1'b0;
  logic               nReset;
  logic               LookupEn;
  logic [INDEX_W-1:0] LookupIndex;
  logic [TAG_W-1:0]   LookupTag;
  logic               Hit, Miss;
  logic [WAY_W-1:0]   HitWay, VictimWay;
  logic               VictimDirty;
  logic [TAG_W-1:0]   VictimTag;
  logic               FillEn;
  logic [INDEX_W-1:0] FillIndex;
  logic [WAY_W-1:0]   FillWay;
  logic [TAG_W-1:0]   FillTag;
  logic               FillDirty, MarkDirty, InvalidateAll, Busy;

  always #5 clk = ~clk;

  tag_array_assoc #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
    .clk(clk), .nReset(nReset),
    .LookupEn(LookupEn), .LookupIndex(LookupIndex), .LookupTag(LookupTag),
    .Hit(Hit), .Miss(Miss), .HitWay(HitWay), .VictimWay(VictimWay),
    .VictimDirty(VictimDirty), .VictimTag(VictimTag),
    .FillEn(FillEn), .FillIndex(FillIndex), .FillWay(FillWay), .FillTag(FillTag),
    .FillDirty(FillDirty), .MarkDirty(MarkDirty), .InvalidateAll(InvalidateAll), .Busy(Busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic        hit;
    logic [31:0] hway, vway, vdirty, vtag;
    bit          chk_tag;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check_value("result_cycle", cyc, e.due);
      check_value("hit", 32'(Hit), 32'(e.hit));
      check_value("miss", 32'(Miss), 32'(!e.hit));
      check_value("hit_way", 32'(HitWay), e.hway);
      check_value("victim_way", 32'(VictimWay), e.vway);
      check_value("victim_dirty", 32'(VictimDirty), e.vdirty);
      if (e.chk_tag) check_value("victim_tag", 32'(VictimTag), e.vtag);
      $display("lookup result @%0d: hit=%0d miss=%0d way=%0d victim=%0d vdirty=%0d vtag=0x%0h",
               cyc, Hit, Miss, HitWay, VictimWay, VictimDirty, VictimTag);
    end else begin
      check_value("hit_quiet", 32'(Hit), 0);
      check_value("miss_quiet", 32'(Miss), 0);
    end
  end

  task automatic lookup(input int idx, input int tag, input bit hit, input int hway,
                        input int vway, input bit vdirty, input int vtag, input bit chk_tag);
    exp_t e;
    LookupEn    = 1'b1;
    LookupIndex = INDEX_W'(idx);
    LookupTag   = TAG_W'(tag);
    e.due = cyc + 1; e.hit = hit; e.hway = hway; e.vway = vway;
    e.vdirty = 32'(vdirty); e.vtag = vtag; e.chk_tag = chk_tag;
    exp_q.push_back(e);
    @(negedge clk);
    LookupEn = 1'b0;
  endtask

  task automatic fill(input int idx, input int way, input int tag, input bit dirty);
    FillEn = 1'b1; FillIndex = INDEX_W'(idx); FillWay = WAY_W'(way);
    FillTag = TAG_W'(tag); FillDirty = dirty;
    @(negedge clk);
    FillEn = 1'b0;
    $display("fill idx=%0d way=%0d tag=0x%0h dirty=%0d", idx, way, tag, dirty);
  endtask

  // Counts Busy cycles while spamming lookups that must be ignored.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (Busy && n < 400) begin
      n++;
      LookupEn = 1'b1; LookupIndex = 5; LookupTag = 12'hABC;
      @(negedge clk);
    end
    LookupEn = 1'b0;
    check_value(tag, n, SETS);
    $display("busy window %s: %0d cycles", tag, n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value(tag, {Busy, Hit, Miss, HitWay, VictimWay, VictimDirty, VictimTag}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0; LookupEn = 1'b0; LookupIndex = '0; LookupTag = '0;
    FillEn = 1'b0; FillIndex = '0; FillWay = '0; FillTag = '0; FillDirty = 1'b0;
    MarkDirty = 1'b0; InvalidateAll = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    nReset = 1'b1;
    #1;
    count_busy("busy_after_reset");

    lookup(5, 'h123, 0, 0, 0, 0, 0, 0);
    fill(5, 1, 'hABC, 0);
    lookup(5, 'hABC, 1, 1, 0, 0, 0, 0);
    lookup(5, 'hABD, 0, 0, 0, 0, 0, 0);

    fill(9, 0, 'h111, 0);
    fill(9, 1, 'h222, 0);
    lookup(9, 'h111, 1, 0, 0, 0, 'h111, 1);
    MarkDirty = 1'b1;
    @(negedge clk);
    MarkDirty = 1'b0;
`ifdef TAG_ARRAY_PLRU_EN
    lookup(9, 'h333, 0, 0, 1, 0, 'h222, 1);
`else
    lookup(9, 'h333, 0, 0, 0, 1, 'h111, 1);
`endif

    // Fill and lookup of the same set in one cycle: lookup sees pre-fill contents.
    FillEn = 1'b1; FillIndex = 3; FillWay = 0; FillTag = 12'h3C3; FillDirty = 1'b0;
    lookup(3, 'h3C3, 0, 0, 0, 0, 0, 0);
    FillEn = 1'b0;
    lookup(3, 'h3C3, 1, 0, 1, 0, 0, 0);

    // Back-to-back lookups, including a miss right after a hit in the same set.
    lookup(5, 'hABC, 1, 1, 0, 0, 0, 0);
    lookup(9, 'h222, 1, 1, 1, 0, 'h222, 1);
`ifdef TAG_ARRAY_PLRU_EN
    lookup(9, 'h444, 0, 0, 0, 1, 'h111, 1);
`else
    lookup(9, 'h444, 0, 0, 1, 0, 'h222, 1);
`endif
    lookup(9, 'h555, 0, 0, 0, 1, 'h111, 1);

    fill(7, 0, 'h070, 1);
    fill(7, 1, 'h071, 0);
`ifdef TAG_ARRAY_PLRU_EN
    lookup(7, 'h999, 0, 0, 0, 1, 'h070, 1);
`else
    lookup(7, 'h999, 0, 0, 1, 0, 'h071, 1);
`endif
    lookup(7, 'h998, 0, 0, 0, 1, 'h070, 1);

    // Sweep requested together with a fill: the fill must not reach the tag RAM.
    fill(20, 0, 'h700, 0);
    FillEn = 1'b1; FillIndex = 20; FillWay = 0; FillTag = 12'h777; InvalidateAll = 1'b1;
    @(negedge clk);
    FillEn = 1'b0; InvalidateAll = 1'b0;
    count_busy("busy_sweep");
    lookup(20, 'h700, 0, 0, 0, 0, 'h700, 1);
    lookup(5, 'hABC, 0, 0, 0, 0, 0, 0);
    lookup(9, 'h111, 0, 0, 0, 0, 'h111, 1);
    lookup(3, 'h3C3, 0, 0, 0, 0, 0, 0);
    lookup(7, 'h070, 0, 0, 0, 0, 'h070, 1);

    // Reset in the middle of a sweep.
    InvalidateAll = 1'b1;
    @(negedge clk);
    InvalidateAll = 1'b0;
    check_value("busy_sweep_start", 32'(Busy), 1);
    repeat (60) @(negedge clk);
    nReset = 1'b0;
    #1;
    check_outputs_zero("reset_mid_sweep");
    @(negedge clk);
    nReset = 1'b1;
    #1;
    count_busy("busy_after_mid_reset");
    lookup(9, 'h111, 0, 0, 0, 0, 'h111, 1);
    lookup(3, 'h3C3, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check_value("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
